mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all address and data widths are fixed at 32 bits and all masks at 4 bits.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL provide the instruction-side requester port:
- imem_read  in  1  read request.
- imem_address  in  32  byte address.
- imem_rdata  out  32  read data.
- imem_resp  out  1  completion pulse.
REQ-004 SHALL provide the data-side requester port:
- dmem_read  in  1  read request.
- dmem_write  in  1  write request.
- dmem_address  in  32  byte address.
- dmem_wdata  in  32  write data.
- dmem_wmask  in  4  byte enables.
- dmem_rdata  out  32  read data.
- dmem_resp  out  1  completion pulse.
REQ-005 SHALL provide the shared memory port:
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_address  out  32  byte address.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte enables.
- mem_rdata  in  32  read data.
- mem_resp  in  1  completion pulse.

Function
REQ-006 SHALL implement an FSM with states IDLE, SERVE_I and SERVE_D.
REQ-007 In IDLE, SHALL treat imem_read as an I request and (dmem_read | dmem_write) as a D request.
REQ-008 Grant policy:
- Only D requesting: grant D.
- Only I requesting: grant I.
- Both requesting: grant D, unless the previous grant was D, in which case grant I (anti-starvation).
REQ-009 On a grant, SHALL capture address, wdata, wmask and read/write kind into internal registers at the same clock edge as the state transition.
REQ-010 SHALL drive mem_* only from the captured registers, so downstream signals stay stable for the whole transaction even if the requester changes its inputs.
REQ-011 Latency: a request sampled in IDLE at edge N SHALL appear on mem_read/mem_write from cycle N+1; the minimum round trip is 2 cycles, with a 1-cycle mem_resp.
REQ-012 In SERVE_x, mem_read or mem_write SHALL remain asserted until mem_resp is sampled high.
REQ-013 On mem_resp in SERVE_x:
- The matching x_resp SHALL be asserted combinationally in the same cycle, for exactly one cycle.
- x_rdata SHALL equal mem_rdata in that cycle.
- The FSM SHALL return to IDLE on the next edge.
REQ-014 A requester's next request SHALL be arbitrated no earlier than the IDLE cycle that follows its resp; there SHALL be no back-to-back grant without an IDLE cycle.
REQ-015 The non-granted requester's resp SHALL stay 0; its rdata SHALL be 0 whenever its resp is 0.
REQ-016 If dmem_read and dmem_write are both asserted, SHALL issue a write only (mem_read=0), and the response SHALL go to D.
REQ-017 SHALL ignore mem_resp while in IDLE, with no state change and no requester resp.
REQ-018 SHALL never assert mem_read and mem_write in the same cycle, and SHALL never assert either in IDLE.
REQ-019 SHALL force mem_wmask=0 and mem_wdata=0 during reads.
REQ-020 SHALL update the last-grant flag on every grant; its reset value is I.

Reset
REQ-021 When rst is high at an edge:
- The FSM SHALL enter IDLE.
- The captured registers SHALL clear to 0.
- The last-grant flag SHALL be set to I.
REQ-022 While in reset and in the first cycle after it, all outputs (mem_*, imem_rdata, imem_resp, dmem_rdata, dmem_resp) SHALL be 0.
REQ-023 Reset mid-transaction SHALL abandon the outstanding access with no resp to either requester; a late mem_resp after reset SHALL be ignored per REQ-017.

Structure
REQ-024 The state enum arb_state_t (IDLE, SERVE_I, SERVE_D) and the grant-owner enum arb_owner_t (OWNER_I, OWNER_D) SHALL live in the shared types package.
REQ-025 SHALL be a single module with one clocked process for state and capture registers and one combinational process for next-state, grant and output decode.
REQ-026 SHALL need no sub-module.

Verification
REQ-027 Single I read: imem_read=1, imem_address=0x60000000; mem_resp=1 two cycles later with mem_rdata=0x00000013 -> mem_read high from cycle 1; imem_resp=1 with imem_rdata=0x00000013 in the mem_resp cycle; dmem_resp stays 0.
REQ-028 Simultaneous requests: imem_read and dmem_read assert together at addresses 0x60000004 and 0x60001000 -> D served first, then one IDLE cycle, then I served; a second simultaneous pair immediately after -> I is granted first (alternation).
REQ-029 D write, wdata=0xDEADBEEF, wmask=4'b0011, address=0x60002000; dmem_address is changed to 0x0 mid-transaction -> mem_write=1, mem_address stays 0x60002000 and mem_wmask stays 0011 until mem_resp; mem_read stays 0 throughout.
REQ-030 Reset during SERVE_D, then a stale mem_resp one cycle later -> no dmem_resp or imem_resp; state is IDLE; all mem_* outputs are 0.
REQ-031 Spurious mem_resp=1 in IDLE with no requests -> no resp to either requester; FSM stays in IDLE.
REQ-032 dmem_read=1 and dmem_write=1 together -> mem_write=1, mem_read=0; dmem_resp fires once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

  // Transaction held stable on the memory port for the whole access.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requesters onto one memory port,
// alternating grants under contention so neither side starves.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [MASK_W-1:0] dmem_wmask,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state, state_nxt;
  arb_owner_t last, last_nxt;
  mem_req_t   cap, cap_nxt;

  logic i_req, d_req, serve_i, serve_d, wr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= OWNER_I;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cap   <= cap_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    cap_nxt      = cap;
    i_req        = imem_read;
    d_req        = dmem_read | dmem_write;
    serve_i      = 1'b0;
    serve_d      = 1'b0;
    wr_c         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    imem_resp    = 1'b0;
    imem_rdata   = '0;
    dmem_resp    = 1'b0;
    dmem_rdata   = '0;

    case (state)
      IDLE: begin
        // D wins contention unless it also won the previous grant.
        if (d_req && (!i_req || last == OWNER_I)) begin
          state_nxt     = SERVE_D;
          last_nxt      = OWNER_D;
          cap_nxt.write = dmem_write;
          cap_nxt.addr  = dmem_address;
          cap_nxt.wdata = dmem_wdata;
          cap_nxt.wmask = dmem_wmask;
        end else if (i_req) begin
          state_nxt     = SERVE_I;
          last_nxt      = OWNER_I;
          cap_nxt.write = 1'b0;
          cap_nxt.addr  = imem_address;
          cap_nxt.wdata = '0;
          cap_nxt.wmask = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Output decode; everything is held at zero while reset is asserted.
    serve_i = (state == SERVE_I) && !rst;
    serve_d = (state == SERVE_D) && !rst;
    wr_c    = serve_d && cap.write;

    mem_read    = serve_i || (serve_d && !cap.write);
    mem_write   = wr_c;
    mem_address = (serve_i || serve_d) ? cap.addr : '0;
    mem_wdata   = wr_c ? cap.wdata : '0;
    mem_wmask   = wr_c ? cap.wmask : '0;

    imem_resp  = serve_i && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : '0;
    dmem_resp  = serve_d && mem_resp;
    dmem_rdata = dmem_resp ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter plus directed reset sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_wmask   (dmem_wmask),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ird;
    logic [31:0] ia;
    logic        drd;
    logic        dwr;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dwm;
    logic [31:0] mrdata;
    logic        mresp;
    logic [135:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [135:0] pk(input logic emr, input logic emw, input logic [31:0] ema,
                                      input logic [31:0] emwd, input logic [3:0] emwm,
                                      input logic eir, input logic [31:0] eird,
                                      input logic edr, input logic [31:0] edrd);
    return {emr, emw, ema, emwd, emwm, eir, eird, edr, edrd};
  endfunction

  function automatic void add(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dwd, input logic [3:0] dwm,
                              input logic [31:0] mrd, input logic mrs,
                              input logic emr, input logic emw, input logic [31:0] ema,
                              input logic [31:0] emwd, input logic [3:0] emwm,
                              input logic eir, input logic [31:0] eird,
                              input logic edr, input logic [31:0] edrd);
    vec_t v;
    v.rst = r;  v.ird = ir; v.ia = ia; v.drd = dr; v.dwr = dw; v.da = da;
    v.dwd = dwd; v.dwm = dwm; v.mrdata = mrd; v.mresp = mrs;
    v.exp = pk(emr, emw, ema, emwd, emwm, eir, eird, edr, edrd);
    tv.push_back(v);
  endfunction

  function automatic logic [135:0] outs();
    return {mem_read, mem_write, mem_address, mem_wdata, mem_wmask,
            imem_resp, imem_rdata, dmem_resp, dmem_rdata};
  endfunction

  task automatic check(input string name, input logic [135:0] exp);
    logic [135:0] got;
    got = outs();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rst;
    imem_read    = v.ird;
    imem_address = v.ia;
    dmem_read    = v.drd;
    dmem_write   = v.dwr;
    dmem_address = v.da;
    dmem_wdata   = v.dwd;
    dmem_wmask   = v.dwm;
    mem_rdata    = v.mrdata;
    mem_resp     = v.mresp;
  endtask

  task automatic idle_inputs();
    imem_read = 1'b0; imem_address = '0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0;
    dmem_wdata = '0; dmem_wmask = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // rst ird ia           drd dwr da           dwd          dwm   mrdata       mresp | mr mw ma           mwd          mwm   ir ird          dr drd
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    // single instruction read
    add(0, 1, 32'h60000000, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     1, 0, 32'h60000000, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h00000013, 1,     1, 0, 32'h60000000, 32'h0,        4'h0, 1, 32'h00000013, 0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    // spurious mem_resp while idle
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'hFFFFFFFF, 1,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    // contention: D first, then I (D re-requests), then D again
    add(0, 1, 32'h60000004, 1, 0, 32'h60001000, 32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 1, 32'h60000004, 1, 0, 32'h60001000, 32'h0,        4'h0, 32'h0,        0,     1, 0, 32'h60001000, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 1, 32'h60000004, 1, 0, 32'h60001000, 32'h0,        4'h0, 32'hAAAA5555, 1,     1, 0, 32'h60001000, 32'h0,        4'h0, 0, 32'h0,        1, 32'hAAAA5555);
    add(0, 1, 32'h60000004, 1, 0, 32'h60001004, 32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 1, 32'h60000004, 1, 0, 32'h60001004, 32'h0,        4'h0, 32'h0,        0,     1, 0, 32'h60000004, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 1, 32'h60000004, 1, 0, 32'h60001004, 32'h0,        4'h0, 32'h00000093, 1,     1, 0, 32'h60000004, 32'h0,        4'h0, 1, 32'h00000093, 0, 32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h60001004, 32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     1, 0, 32'h60001004, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h12345678, 1,     1, 0, 32'h60001004, 32'h0,        4'h0, 0, 32'h0,        1, 32'h12345678);
    // write held stable while requester inputs change
    add(0, 0, 32'h0,        0, 1, 32'h60002000, 32'hDEADBEEF, 4'h3, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 1, 32'h60002000, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 1, 32'h60002000, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1,     0, 1, 32'h60002000, 32'hDEADBEEF, 4'h3, 0, 32'h0,        1, 32'hCAFEF00D);
    // read and write together -> write only
    add(0, 0, 32'h0,        1, 1, 32'h60003000, 32'h11223344, 4'hF, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 1, 32'h60003000, 32'h11223344, 4'hF, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        1,     0, 1, 32'h60003000, 32'h11223344, 4'hF, 0, 32'h0,        1, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    // D read with junk wdata/wmask -> forced to zero on the bus
    add(0, 0, 32'h0,        1, 0, 32'h60004000, 32'hFFFFFFFF, 4'hF, 32'h0,        0,     0, 0, 32'h0,        32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0,     1, 0, 32'h60004000, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        4'h0, 32'h5A5A5A5A, 1,     1, 0, 32'h60004000, 32'h0,        4'h0, 0, 32'h0,        1, 32'h5A5A5A5A);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tv[i].exp);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a D access, then a stale mem_resp.
    idle_inputs();
    rst = 1'b0;
    dmem_read = 1'b1; dmem_address = 32'h60005000;
    @(negedge clk); check("rst_req_idle", pk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    dmem_read = 1'b0; dmem_address = '0;
    @(negedge clk); check("rst_serve_d", pk(1, 0, 32'h60005000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); check("rst_during", pk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hDEAD0001;
    @(negedge clk); check("rst_stale_resp", pk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = '0;
    @(negedge clk); check("rst_still_idle", pk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;

    // Arbiter is usable again after reset: last grant reads back as I.
    imem_read = 1'b1; imem_address = 32'h60000008;
    dmem_read = 1'b1; dmem_address = 32'h60006000;
    @(posedge clk); #1;
    imem_read = 1'b0; dmem_read = 1'b0;
    @(negedge clk); check("post_rst_grant_d", pk(1, 0, 32'h60006000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'h00000077;
    @(negedge clk); check("post_rst_resp_d", pk(1, 0, 32'h60006000, 32'h0, 4'h0, 0, 32'h0, 1, 32'h00000077));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk); check("post_rst_idle", pk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
